// File: rtl/s2p_pkg.sv
// Shared types and default sizing for the MSDAP serial-to-parallel input path.
package s2p_pkg;
    typedef enum logic {IDLE, SHIFT} s2p_state_t;

    localparam int S2P_WIDTH  = 16;
    localparam int S2P_NUM_CH = 2;
endpackage

// File: rtl/s2p_multi_if.sv
// Serial stream in, parallel word out with valid/ready and sticky status flags.
interface s2p_multi_if #(
    parameter int WIDTH  = s2p_pkg::S2P_WIDTH,
    parameter int NUM_CH = s2p_pkg::S2P_NUM_CH
) ();
    logic                    Frame;
    logic [NUM_CH-1:0]       serial_in;
    logic                    out_ready;
    logic                    clr_flags;
    logic [NUM_CH*WIDTH-1:0] parallel_out;
    logic                    out_valid;
    logic                    busy;
    logic                    overrun;
    logic                    sync_err;

    // master feeds the stream and consumes words; slave is the deserializer
    modport master (
        output Frame, serial_in, out_ready, clr_flags,
        input  parallel_out, out_valid, busy, overrun, sync_err
    );
    modport slave (
        input  Frame, serial_in, out_ready, clr_flags,
        output parallel_out, out_valid, busy, overrun, sync_err
    );
endinterface

// File: rtl/s2p_lane.sv
// One-channel shift register; word presents the value including the bit sampled this edge.
module s2p_lane #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sample,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;

    always_comb begin
        sr_next = sr_reg;
        if (LSB_FIRST)
            sr_next = {sample, sr_reg[WIDTH-1:1]};
        else
            sr_next = {sr_reg[WIDTH-2:0], sample};
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            sr_reg <= '0;
        else if (shift_en)
            sr_reg <= sr_next;
    end

    assign word = sr_next;
endmodule

// File: rtl/s2p_multi.sv
// Multi-channel deserializer: Frame-aligned word capture, output register, handshake and flags.
module s2p_multi
    import s2p_pkg::*;
#(
    parameter int WIDTH      = S2P_WIDTH,
    parameter int NUM_CH     = S2P_NUM_CH,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic        DCLK,
    input  logic        clear,
    s2p_multi_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    s2p_state_t              state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [NUM_CH*WIDTH-1:0] pout_reg, pout_next;
    logic                    valid_reg, valid_next;
    logic                    overrun_reg, overrun_next;
    logic                    sync_err_reg, sync_err_next;
    logic [NUM_CH*WIDTH-1:0] word_all;
    logic                    shift_en;
    logic                    complete;
    logic                    resync;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
        s2p_lane #(
            .WIDTH     (WIDTH),
            .LSB_FIRST (LSB_FIRST)
        ) u_lane (
            .clk      (DCLK),
            .rst      (clear),
            .shift_en (shift_en),
            .sample   (bus.serial_in[gi]),
            .word     (word_all[gi*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_en   = 1'b0;
        complete   = 1'b0;
        resync     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.Frame) begin
                    shift_en   = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                // A Frame at cnt==0 is a legal back-to-back boundary, not a resync
                if (bus.Frame && cnt_reg != '0) begin
                    resync   = 1'b1;
                    cnt_next = CW'(1);
                end else if (cnt_reg == LAST) begin
                    complete   = 1'b1;
                    cnt_next   = '0;
                    state_next = CONTINUOUS ? SHIFT : IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pout_next  = pout_reg;
        valid_next = valid_reg;
        if (complete) begin
            pout_next  = word_all;
            valid_next = 1'b1;
        end else if (valid_reg && bus.out_ready) begin
            valid_next = 1'b0;
        end
        // Set events take priority over a coincident clear
        if (complete && valid_reg && !bus.out_ready)
            overrun_next = 1'b1;
        else if (bus.clr_flags)
            overrun_next = 1'b0;
        else
            overrun_next = overrun_reg;
        if (resync)
            sync_err_next = 1'b1;
        else if (bus.clr_flags)
            sync_err_next = 1'b0;
        else
            sync_err_next = sync_err_reg;
    end

    always_ff @(negedge DCLK or posedge clear) begin
        if (clear) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            pout_reg     <= '0;
            valid_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pout_reg     <= pout_next;
            valid_reg    <= valid_next;
            overrun_reg  <= overrun_next;
            sync_err_reg <= sync_err_next;
        end
    end

    assign bus.parallel_out = pout_reg;
    assign bus.out_valid    = valid_reg;
    assign bus.busy         = (state_reg == SHIFT);
    assign bus.overrun      = overrun_reg;
    assign bus.sync_err     = sync_err_reg;
endmodule
